fm_dac_mux_tx: RTL and testbench
================================

Name: fm_dac_mux_tx

Overview:
- Transmit side of the FM DAC time-multiplexed output interface consumed by the audio conditioning path.
- Accepts one six-channel stereo FM sample frame at a time through a valid/ready handshake.
- Serialises each frame onto slot-multiplexed MOL/MOR buses, in both the 9-bit offset-binary (YM3438-style) and 10-bit signed (YM2612-style) formats, with the fm_clk1 slot clock and the fm_sel23 end-of-frame strobe.
- Used as the FM-core output stage and as the stimulus source for the audio path bench.

Parameters:
- IDLE_SLOTS, 0, number of extra zero-contribution slots appended after channel slots 0..5 in each frame; range 0..18.

Ports:
- clk  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- ce  in  1  FM clock enable; each pulse advances one half slot
- chan_en  in  6  per-channel enable; bit n gates channel n
- in_l  in  54  left frame; channel n occupies bits [9n+8:9n], signed two's complement
- in_r  in  54  right frame; same layout as in_l
- in_valid  in  1  frame offered
- in_ready  out  1  shadow buffer empty
- fm_clk1  out  1  slot clock
- fm_sel23  out  1  high during the last slot of the frame
- MOL  out  9  left sample, offset binary (MSB inverted)
- MOR  out  9  right sample, offset binary (MSB inverted)
- MOL_2612  out  10  left sample, signed, sign-extended
- MOR_2612  out  10  right sample, signed, sign-extended
- underrun  out  1  one-cycle pulse at frame start when no new frame was available

Behaviour:
- Reset (async, RST_N low) values: fm_clk1=0, fm_sel23=0, MOL=MOR=9'h100, MOL_2612=MOR_2612=0, in_ready=1, underrun=0.
- Reset also sets: active and shadow buffers to 0, shadow_full=0, slot=N-1 where N=6+IDLE_SLOTS.
- Slot timing:
  - ce with fm_clk1=0 is a rising edge. fm_clk1 goes to 1, slot advances to (slot+1) mod N, and MOL/MOR/MOL_2612/MOR_2612/fm_sel23 update on the same clk edge.
  - ce with fm_clk1=1 is a falling edge. fm_clk1 goes to 0 and nothing else changes.
  - The downstream consumer samples on the falling edge, so data is stable for the full slot.
  - Slot period is 2 ce pulses; frame period is 2N ce pulses.
- fm_sel23 is 1 exactly when the new slot equals N-1, else 0.
- Slot content:
  - Slot n<6 with chan_en[n]=1 carries active channel n.
  - A disabled channel slot, and any idle slot (n>=6), carries zero: MOL=9'h100, MOL_2612=0.
- Format: for sample s[8:0], MOL={~s[8],s[7:0]} and MOL_2612={s[8],s}. MOR/MOR_2612 are identical from the right frame.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - On transfer, in_l/in_r are captured into the shadow buffer, shadow_full is set and in_ready drops on the next cycle.
  - in_ready = ~shadow_full.
- Frame swap, on a rising edge where the slot wraps to 0:
  - If shadow_full, copy shadow to active and clear shadow_full; in_ready rises the next cycle.
  - Otherwise keep active unchanged (the last frame repeats) and pulse underrun for 1 clk.
  - The decision uses the registered shadow_full. A transfer in the same clk as the swap fills the shadow only, so that swap still underruns and the new frame is used at the next frame start.
- The first frame after reset is all zeros and signals underrun at its start unless the shadow was filled earlier.
- chan_en is sampled at each rising edge, not latched per frame.
- ce held low: all state frozen and the handshake still works; at most one frame is buffered.
- Reset mid-frame: immediate return to reset values; any pending shadow frame is discarded.

Test Plan:
- Reset, load frame of all channels 9'd10 both sides, IDLE_SLOTS=0, ce every clk -> fm_sel23 high 1 slot in 6, period 12 clk; receiver model (accumulate MOL_2612 on falling edges, dump on sel23) yields 60 per frame from the second frame on.
- Channel 0 = 9'h1FF (-1), channel 1 = 9'h100 (-256), channel 2 = 9'h0FF (255) -> MOL 9'h0FF / 9'h000 / 9'h1FF, MOL_2612 10'h3FF / 10'h300 / 10'h0FF.
- One frame loaded then in_valid=0 -> frame repeats; underrun pulses exactly 1 clk at each slot-0 rising edge; in_ready stays 1.
- Transfer in the same clk as the wrap to slot 0 -> underrun=1 on that swap; the new data appears from the next frame; in_ready low until that swap.
- chan_en=6'b111110 with all channels 9'd5 -> slot 0 shows MOL=9'h100 and MOL_2612=0; frame sum is 25.
- IDLE_SLOTS=18, RST_N pulsed low mid-slot 3 -> outputs return to reset values asynchronously; after release the first rising edge gives slot 0; fm_sel23 period is 48 ce.

Source files
------------

// File: rtl/fm_dac_mux_tx.sv
// fm_dac_mux_tx: transmit side of the FM DAC time-multiplexed output interface.
//
// Takes one six-channel stereo frame at a time through a valid/ready handshake
// and plays it out slot by slot. The outputs are the YM3438-style 9-bit
// offset-binary buses (MOL/MOR) and the YM2612-style 10-bit signed buses
// (MOL_2612/MOR_2612), together with the fm_clk1 slot clock and the fm_sel23
// last-slot strobe. Each frame has 6 channel slots followed by IDLE_SLOTS
// silent slots.
//
// Ports:
//   clk        system clock
//   RST_N      asynchronous active-low reset
//   ce         FM clock enable; each pulse advances one half slot
//   chan_en    per-channel enable; bit n gates channel n
//   in_l/in_r  frame input; channel n is at bits [9n+8:9n], two's complement
//   in_valid   a frame is offered
//   in_ready   the shadow buffer is empty
//   fm_clk1    slot clock; data changes on its rising edge
//   fm_sel23   high during the last slot of the frame
//   MOL/MOR    9-bit offset-binary samples
//   MOL_2612/MOR_2612  10-bit sign-extended samples
//   underrun   one-cycle pulse at frame start when no new frame was waiting
module fm_dac_mux_tx #(
  parameter int IDLE_SLOTS = 0
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        ce,
  input  logic [5:0]  chan_en,
  input  logic [53:0] in_l,
  input  logic [53:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        fm_clk1,
  output logic        fm_sel23,
  output logic [8:0]  MOL,
  output logic [8:0]  MOR,
  output logic [9:0]  MOL_2612,
  output logic [9:0]  MOR_2612,
  output logic        underrun
);

  localparam int N  = 6 + IDLE_SLOTS;
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [53:0]   act_l, act_r;
  logic [53:0]   sh_l, sh_r;
  logic          shadow_full;
  logic [SW-1:0] slot;
  logic [SW-1:0] slot_nxt;
  logic          rise;
  logic          wrap;
  logic          swap;
  logic          xfer;
  logic [53:0]   src_l, src_r;
  logic [8:0]    smp_l, smp_r;

  assign in_ready = ~shadow_full;
  assign xfer     = in_valid & ~shadow_full;
  assign rise     = ce & ~fm_clk1;
  assign slot_nxt = (slot == LAST) ? '0 : slot + 1'b1;
  assign wrap     = rise & (slot_nxt == '0);
  // The swap decision uses the registered shadow_full, so a frame accepted in
  // the same cycle as the wrap only lands in the shadow and waits a frame.
  assign swap     = wrap & shadow_full;

  // Slot 0 of a freshly swapped frame must already show the new data.
  assign src_l = swap ? sh_l : act_l;
  assign src_r = swap ? sh_r : act_r;

  // Disabled channels and idle slots contribute a zero sample.
  always_comb begin
    smp_l = '0;
    smp_r = '0;
    for (int i = 0; i < 6; i++) begin
      if ((slot_nxt == SW'(i)) && chan_en[i]) begin
        smp_l = src_l[9*i +: 9];
        smp_r = src_r[9*i +: 9];
      end
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      act_l       <= '0;
      act_r       <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      shadow_full <= 1'b0;
      slot        <= LAST;
      fm_clk1     <= 1'b0;
      fm_sel23    <= 1'b0;
      MOL         <= 9'h100;
      MOR         <= 9'h100;
      MOL_2612    <= '0;
      MOR_2612    <= '0;
      underrun    <= 1'b0;
    end else begin
      underrun <= 1'b0;

      if (ce) begin
        if (rise) begin
          fm_clk1  <= 1'b1;
          slot     <= slot_nxt;
          fm_sel23 <= (slot_nxt == LAST);
          MOL      <= {~smp_l[8], smp_l[7:0]};
          MOR      <= {~smp_r[8], smp_r[7:0]};
          MOL_2612 <= {smp_l[8], smp_l};
          MOR_2612 <= {smp_r[8], smp_r};
          if (wrap && !shadow_full) begin
            underrun <= 1'b1;
          end
        end else begin
          fm_clk1 <= 1'b0;
        end
      end

      if (swap) begin
        act_l <= sh_l;
        act_r <= sh_r;
      end

      // xfer and swap are exclusive: xfer needs an empty shadow, swap a full one.
      if (xfer) begin
        sh_l        <= in_l;
        sh_r        <= in_r;
        shadow_full <= 1'b1;
      end else if (swap) begin
        shadow_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fm_dac_mux_tx.sv
// tb_fm_dac_mux_tx: self-checking bench for fm_dac_mux_tx.
//
// Two instances are used: u_dut0 (IDLE_SLOTS=0, ce every clk) and u_dut1
// (IDLE_SLOTS=18, ce every other clk). A frame-level model predicts every
// output on each clock. A small receiver turns instance 0's bus back into
// per-slot samples and frame sums, which are compared against literal values
// worked out by hand.
module tb_fm_dac_mux_tx;

  logic        clk = 1'b0;
  logic        ce0;
  logic        ce1 = 1'b0;
  logic        rst_n    [2];
  logic [5:0]  chan_en  [2];
  logic [53:0] in_l     [2];
  logic [53:0] in_r     [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic        fm_clk1  [2];
  logic        fm_sel23 [2];
  logic [8:0]  MOL      [2];
  logic [8:0]  MOR      [2];
  logic [9:0]  MOL_2612 [2];
  logic [9:0]  MOR_2612 [2];
  logic        underrun [2];

  int nchecks = 0;
  int nerrors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;
  always @(negedge clk) ce1 = ~ce1;

  fm_dac_mux_tx #(.IDLE_SLOTS(0)) u_dut0 (
    .clk(clk), .RST_N(rst_n[0]), .ce(ce0), .chan_en(chan_en[0]),
    .in_l(in_l[0]), .in_r(in_r[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .fm_clk1(fm_clk1[0]), .fm_sel23(fm_sel23[0]), .MOL(MOL[0]), .MOR(MOR[0]),
    .MOL_2612(MOL_2612[0]), .MOR_2612(MOR_2612[0]), .underrun(underrun[0])
  );

  fm_dac_mux_tx #(.IDLE_SLOTS(18)) u_dut1 (
    .clk(clk), .RST_N(rst_n[1]), .ce(ce1), .chan_en(chan_en[1]),
    .in_l(in_l[1]), .in_r(in_r[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .fm_clk1(fm_clk1[1]), .fm_sel23(fm_sel23[1]), .MOL(MOL[1]), .MOR(MOR[1]),
    .MOL_2612(MOL_2612[1]), .MOR_2612(MOR_2612[1]), .underrun(underrun[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [53:0] pack6(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5);
    logic [8:0] v [6];
    v[0] = 9'(a0); v[1] = 9'(a1); v[2] = 9'(a2);
    v[3] = 9'(a3); v[4] = 9'(a4); v[5] = 9'(a5);
    return {v[5], v[4], v[3], v[2], v[1], v[0]};
  endfunction

  // ---------------- frame-level model ----------------
  int m_slot  [2];
  bit m_clk1  [2];
  bit m_full  [2];
  int act_l   [2][6];
  int act_r   [2][6];
  int sh_l    [2][6];
  int sh_r    [2][6];
  int e_sel23 [2];
  int e_mol   [2];
  int e_mor   [2];
  int e_ml26  [2];
  int e_mr26  [2];
  int e_under [2];

  function automatic int nslots(input int k);
    return (k == 0) ? 6 : 24;
  endfunction

  function automatic bit ce_of(input int k);
    return (k == 0) ? ce0 : ce1;
  endfunction

  task automatic model_reset(input int k);
    m_slot[k] = nslots(k) - 1;
    m_clk1[k] = 1'b0;
    m_full[k] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      act_l[k][c] = 0; act_r[k][c] = 0; sh_l[k][c] = 0; sh_r[k][c] = 0;
    end
    e_sel23[k] = 0; e_mol[k] = 256; e_mor[k] = 256;
    e_ml26[k] = 0; e_mr26[k] = 0; e_under[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit was_full = m_full[k];
    int sl = 0;
    int sr = 0;
    e_under[k] = 0;
    if (ce_of(k)) begin
      if (!m_clk1[k]) begin
        m_clk1[k] = 1'b1;
        m_slot[k] = (m_slot[k] + 1) % nslots(k);
        if (m_slot[k] == 0) begin
          if (was_full) begin
            for (int c = 0; c < 6; c++) begin
              act_l[k][c] = sh_l[k][c];
              act_r[k][c] = sh_r[k][c];
            end
            m_full[k] = 1'b0;
          end else begin
            e_under[k] = 1;
          end
        end
        e_sel23[k] = (m_slot[k] == nslots(k) - 1) ? 1 : 0;
        if (m_slot[k] < 6 && chan_en[k][m_slot[k]]) begin
          sl = act_l[k][m_slot[k]];
          sr = act_r[k][m_slot[k]];
        end
        e_mol[k]  = sl + 256;
        e_mor[k]  = sr + 256;
        e_ml26[k] = (sl + 1024) % 1024;
        e_mr26[k] = (sr + 1024) % 1024;
      end else begin
        m_clk1[k] = 1'b0;
      end
    end
    if (in_valid[k] && !was_full) begin
      for (int c = 0; c < 6; c++) begin
        sh_l[k][c] = int'($signed(in_l[k][9*c +: 9]));
        sh_r[k][c] = int'($signed(in_r[k][9*c +: 9]));
      end
      m_full[k] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n[k] === 1'b1) model_step(k);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("fm_clk1[%0d]", k),  int'(fm_clk1[k]),  int'(m_clk1[k]));
        chk($sformatf("fm_sel23[%0d]", k), int'(fm_sel23[k]), e_sel23[k]);
        chk($sformatf("MOL[%0d]", k),      int'(MOL[k]),      e_mol[k]);
        chk($sformatf("MOR[%0d]", k),      int'(MOR[k]),      e_mor[k]);
        chk($sformatf("MOL_2612[%0d]", k), int'(MOL_2612[k]), e_ml26[k]);
        chk($sformatf("MOR_2612[%0d]", k), int'(MOR_2612[k]), e_mr26[k]);
        chk($sformatf("underrun[%0d]", k), int'(underrun[k]), e_under[k]);
        chk($sformatf("in_ready[%0d]", k), int'(in_ready[k]), m_full[k] ? 0 : 1);
      end
    end
  end

  // ---------------- receiver on instance 0 ----------------
  int acc = 0;
  int last_sum = 0;
  int rx_idx = -1;
  bit prev_clk1 = 1'b0;
  bit prev_sel = 1'b0;
  int mol_cap [6];
  int mor_cap [6];
  int m26_cap [6];
  int cnt0 = 0;
  int per0 = 0;
  bit ps0 = 1'b0;

  always @(negedge clk) begin
    if (rst_n[0] === 1'b1) begin
      if (fm_clk1[0] && !prev_clk1) begin
        rx_idx = prev_sel ? 0 : rx_idx + 1;
        if (rx_idx >= 0 && rx_idx < 6) begin
          mol_cap[rx_idx] = int'(MOL[0]);
          mor_cap[rx_idx] = int'(MOR[0]);
          m26_cap[rx_idx] = int'(MOL_2612[0]);
        end
      end
      if (!fm_clk1[0] && prev_clk1) begin
        acc = acc + int'($signed(MOL_2612[0]));
        if (fm_sel23[0]) begin
          last_sum = acc;
          acc = 0;
        end
      end
      prev_clk1 = fm_clk1[0];
      prev_sel  = fm_sel23[0];
      cnt0++;
      if (fm_sel23[0] && !ps0) begin
        per0 = cnt0;
        cnt0 = 0;
      end
      ps0 = fm_sel23[0];
    end
  end

  // fm_sel23 period of instance 1, measured in ce pulses
  int cecnt1 = 0;
  int last1 = 0;
  int per1 = 0;
  bit ps1 = 1'b0;
  always @(posedge clk) if (rst_n[1] === 1'b1 && ce1) cecnt1++;
  always @(negedge clk) begin
    if (fm_sel23[1] === 1'b1 && !ps1) begin
      per1  = cecnt1 - last1;
      last1 = cecnt1;
    end
    ps1 = (fm_sel23[1] === 1'b1);
  end

  task automatic load(input int k, input logic [53:0] l, input logic [53:0] r);
    int t = 0;
    @(negedge clk);
    in_l[k] = l;
    in_r[k] = r;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("load_wait", (t < 400) ? 1 : 0, 1);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  initial begin
    int ur;
    int nr;
    int t;
    ce0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b1; chan_en[k] = 6'h3F;
      in_l[k] = '0; in_r[k] = '0; in_valid[k] = 1'b0;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    model_reset(0);
    model_reset(1);
    started = 1'b1;
    #2;
    chk("rst_MOL",      int'(MOL[0]),      9'h100);
    chk("rst_MOR_2612", int'(MOR_2612[0]), 0);
    chk("rst_fm_clk1",  int'(fm_clk1[0]),  0);
    chk("rst_in_ready", int'(in_ready[0]), 1);
    chk("rst_underrun", int'(underrun[0]), 0);

    // all channels 10: frame sum 60, repeat with underrun each frame start
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    ce0 = 1'b1;
    load(0, pack6(10, 10, 10, 10, 10, 10), pack6(10, 10, 10, 10, 10, 10));
    repeat (24) @(negedge clk);
    ur = 0; nr = 0;
    repeat (36) begin
      @(negedge clk); #1;
      if (underrun[0]) ur++;
      if (!in_ready[0]) nr++;
    end
    chk("repeat_underruns", ur, 3);
    chk("repeat_in_ready_low", nr, 0);
    chk("sum_10", last_sum, 60);
    chk("sel23_period_clk", per0, 12);

    // format corners
    load(0, pack6(-1, -256, 255, 0, 0, 0), pack6(255, -256, -1, 0, 0, 0));
    repeat (30) @(negedge clk);
    #1;
    chk("mol_m1",     mol_cap[0], 9'h0FF);
    chk("mol_m256",   mol_cap[1], 9'h000);
    chk("mol_p255",   mol_cap[2], 9'h1FF);
    chk("m26_m1",     m26_cap[0], 10'h3FF);
    chk("m26_m256",   m26_cap[1], 10'h300);
    chk("m26_p255",   m26_cap[2], 10'h0FF);
    chk("mor_p255",   mor_cap[0], 9'h1FF);
    chk("corner_sum", last_sum, -2);

    // transfer in the same clk as the wrap to slot 0
    t = 0;
    @(negedge clk);
    while (!(fm_sel23[0] && fm_clk1[0]) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("find_last_slot", (t < 50) ? 1 : 0, 1);
    @(negedge clk);
    in_l[0] = pack6(7, 7, 7, 7, 7, 7);
    in_r[0] = pack6(7, 7, 7, 7, 7, 7);
    in_valid[0] = 1'b1;
    @(negedge clk); #1;
    in_valid[0] = 1'b0;
    chk("wrap_underrun", int'(underrun[0]), 1);
    chk("wrap_in_ready", int'(in_ready[0]), 0);
    nr = 0;
    repeat (11) begin
      @(negedge clk); #1;
      if (in_ready[0]) nr++;
    end
    chk("held_until_swap", nr, 0);
    chk("old_frame_sum", last_sum, -2);
    @(negedge clk); #1;
    chk("ready_after_swap", int'(in_ready[0]), 1);
    chk("swap_no_underrun", int'(underrun[0]), 0);
    chk("swap_slot0_mol", int'(MOL[0]), 9'h107);
    repeat (11) @(negedge clk);
    #1;
    chk("new_frame_sum", last_sum, 42);

    // channel 0 disabled
    @(negedge clk);
    chan_en[0] = 6'b111110;
    load(0, pack6(5, 5, 5, 5, 5, 5), pack6(5, 5, 5, 5, 5, 5));
    repeat (30) @(negedge clk);
    #1;
    chk("dis_mol",  mol_cap[0], 9'h100);
    chk("dis_m26",  m26_cap[0], 0);
    chk("en_mol",   mol_cap[1], 9'h105);
    chk("dis_sum",  last_sum, 25);

    // instance 1: 18 idle slots, ce every other clk
    @(negedge clk);
    rst_n[1] = 1'b1;
    load(1, pack6(1, 2, 3, 4, 5, 6), pack6(-1, -2, -3, -4, -5, -6));
    repeat (260) @(negedge clk);
    #1;
    chk("sel23_period_ce", per1, 48);

    t = 0;
    while (m_slot[1] != 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("find_slot2", (t < 200) ? 1 : 0, 1);
    load(1, pack6(9, 9, 9, 9, 9, 9), pack6(9, 9, 9, 9, 9, 9));
    t = 0;
    while (m_slot[1] != 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("find_slot3", (t < 50) ? 1 : 0, 1);
    chk("pre_rst_in_ready", int'(in_ready[1]), 0);
    #2;
    rst_n[1] = 1'b0;
    model_reset(1);
    #1;
    chk("arst_fm_clk1",  int'(fm_clk1[1]),  0);
    chk("arst_sel23",    int'(fm_sel23[1]), 0);
    chk("arst_MOL",      int'(MOL[1]),      9'h100);
    chk("arst_MOR",      int'(MOR[1]),      9'h100);
    chk("arst_MOL_2612", int'(MOL_2612[1]), 0);
    chk("arst_in_ready", int'(in_ready[1]), 1);
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!fm_clk1[1] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("post_rst_rise", (t < 20) ? 1 : 0, 1);
    chk("post_rst_underrun", int'(underrun[1]), 1);
    chk("post_rst_sel23",    int'(fm_sel23[1]), 0);
    chk("post_rst_MOL",      int'(MOL[1]),      9'h100);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
